// File: rtl/muldiv_pkg.sv
// Shared types and helpers for the M-extension multiply/divide unit.
//   muldiv_op_e    : funct3 encodings of the eight M operations
//   muldiv_state_e : control states of ex_muldiv_unit
package muldiv_pkg;

  localparam int unsigned OP_W = 3;
  localparam int unsigned RD_W = 5;

  typedef enum logic [OP_W-1:0] {
    OP_MUL    = 3'd0,
    OP_MULH   = 3'd1,
    OP_MULHSU = 3'd2,
    OP_MULHU  = 3'd3,
    OP_DIV    = 3'd4,
    OP_DIVU   = 3'd5,
    OP_REM    = 3'd6,
    OP_REMU   = 3'd7
  } muldiv_op_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_MUL,
    ST_DIV,
    ST_FIX,
    ST_DONE
  } muldiv_state_e;

  // rs1 is interpreted as a signed value by this operation
  function automatic logic is_signed_op(muldiv_op_e op);
    return (op == OP_MUL) || (op == OP_MULH) || (op == OP_MULHSU) ||
           (op == OP_DIV) || (op == OP_REM);
  endfunction

  // DIV/DIVU/REM/REMU share funct3[2]
  function automatic logic is_div_op(muldiv_op_e op);
    return op[2];
  endfunction

endpackage

// File: rtl/ex_muldiv_unit_if.sv
// Request/response bundle between the Execute stage and the mul/div unit.
//   master : pipeline side (drives start/op/a/b/rd_in/flush/hold)
//   slave  : ex_muldiv_unit (drives stall/res_valid/res/rd_out)
interface ex_muldiv_unit_if #(
  parameter int unsigned XLEN = 32
);
  import muldiv_pkg::*;

  logic            start;
  logic [OP_W-1:0] op;
  logic [XLEN-1:0] a;
  logic [XLEN-1:0] b;
  logic [RD_W-1:0] rd_in;
  logic            flush;
  logic            hold;
  logic            stall;
  logic            res_valid;
  logic [XLEN-1:0] res;
  logic [RD_W-1:0] rd_out;

  modport master (
    output start, op, a, b, rd_in, flush, hold,
    input  stall, res_valid, res, rd_out
  );

  modport slave (
    input  start, op, a, b, rd_in, flush, hold,
    output stall, res_valid, res, rd_out
  );

endinterface

// File: rtl/muldiv_divider.sv
// Restoring radix-2 unsigned divider, one quotient bit per clock.
//   start_i             : load dividend/divisor magnitudes, begin XLEN iterations
//   flush_i             : abandon the current division
//   quot_o / rem_o      : final once done_c_o has been seen
//   done_c_o            : high in the cycle of the last iteration
module muldiv_divider #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_i,
  input  logic            start_i,
  input  logic            flush_i,
  input  logic [XLEN-1:0] dividend_i,
  input  logic [XLEN-1:0] divisor_i,
  output logic [XLEN-1:0] quot_o,
  output logic [XLEN-1:0] rem_o,
  output logic            done_c_o
);

  localparam int unsigned CNT_W = $clog2(XLEN);

  logic             busy_q, busy_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [XLEN-1:0]  quot_q, quot_d;
  logic [XLEN-1:0]  rem_q, rem_d;
  logic [XLEN-1:0]  dvsr_q, dvsr_d;
  logic [XLEN:0]    partial, diff;

  // Shift the next dividend bit into the partial remainder and trial-subtract.
  assign partial  = {rem_q, quot_q[XLEN-1]};
  assign diff     = partial - {1'b0, dvsr_q};
  assign done_c_o = busy_q && (cnt_q == CNT_W'(XLEN - 1));

  always_comb begin
    busy_d = busy_q;
    cnt_d  = cnt_q;
    quot_d = quot_q;
    rem_d  = rem_q;
    dvsr_d = dvsr_q;
    if (flush_i) begin
      busy_d = 1'b0;
    end else if (start_i) begin
      busy_d = 1'b1;
      cnt_d  = '0;
      quot_d = dividend_i;
      rem_d  = '0;
      dvsr_d = divisor_i;
    end else if (busy_q) begin
      // Borrow out means the divisor did not fit: restore and shift in 0.
      if (diff[XLEN]) begin
        rem_d  = partial[XLEN-1:0];
        quot_d = {quot_q[XLEN-2:0], 1'b0};
      end else begin
        rem_d  = diff[XLEN-1:0];
        quot_d = {quot_q[XLEN-2:0], 1'b1};
      end
      cnt_d = cnt_q + CNT_W'(1);
      if (done_c_o) busy_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_i) begin
      busy_q <= 1'b0;
      cnt_q  <= '0;
      quot_q <= '0;
      rem_q  <= '0;
      dvsr_q <= '0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
      quot_q <= quot_d;
      rem_q  <= rem_d;
      dvsr_q <= dvsr_d;
    end
  end

  assign quot_o = quot_q;
  assign rem_o  = rem_q;

endmodule

// File: rtl/ex_muldiv_unit.sv
// Multi-cycle RISC-V M-extension execute unit beside the single-cycle ALU.
//   clk, Rst (sync, active-high)
//   mdu.start/op/a/b/rd_in : request with forwarded operands
//   mdu.flush              : kill in-flight op; mdu.hold : downstream hold
//   mdu.stall              : freeze ID/EX -> EX/MEM while busy
//   mdu.res_valid/res/rd_out : result and destination tag
module ex_muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int unsigned XLEN      = 32,
  parameter int unsigned MUL_LAT   = 3,
  parameter int unsigned EARLY_OUT = 1
) (
  input logic             clk,
  input logic             Rst,
  ex_muldiv_unit_if.slave mdu
);

  localparam int unsigned     CNT_W    = 3;
  localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

  muldiv_state_e   state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [XLEN-1:0] res_q, res_d;
  logic [XLEN-1:0] a_q, a_d;
  logic [RD_W-1:0] rd_q, rd_d;
  logic            rem_sel_q, rem_sel_d;
  logic            dz_q, dz_d;
  logic            spec_q, spec_d;
  logic            qneg_q, qneg_d;
  logic            rneg_q, rneg_d;

  // Request decode from the forwarded operands.
  muldiv_op_e      op_in;
  logic            a_sgn, b_sgn, dz_in, ovf_in, spec_in;
  logic [XLEN-1:0] a_mag, b_mag;

  assign op_in   = muldiv_op_e'(mdu.op);
  assign a_sgn   = is_signed_op(op_in);
  assign b_sgn   = a_sgn && (op_in != OP_MULHSU);
  assign dz_in   = (mdu.b == '0);
  assign ovf_in  = a_sgn && (mdu.a == MOST_NEG) && (mdu.b == '1);
  assign spec_in = dz_in || ovf_in;
  assign a_mag   = (a_sgn && mdu.a[XLEN-1]) ? -mdu.a : mdu.a;
  assign b_mag   = (b_sgn && mdu.b[XLEN-1]) ? -mdu.b : mdu.b;

  // Multiplier: the low 2*XLEN bits of a product of 2*XLEN-bit extended
  // operands equal the full signed/unsigned product.
  logic [2*XLEN-1:0] mul_opa, mul_opb, mul_prod;
  logic [XLEN-1:0]   mul_word, mul_tap;

  assign mul_opa  = {{XLEN{a_sgn & mdu.a[XLEN-1]}}, mdu.a};
  assign mul_opb  = {{XLEN{b_sgn & mdu.b[XLEN-1]}}, mdu.b};
  assign mul_prod = mul_opa * mul_opb;
  assign mul_word = (op_in == OP_MUL) ? mul_prod[XLEN-1:0] : mul_prod[2*XLEN-1:XLEN];

  // Result word travels MUL_LAT-1 registers before res_q captures it.
  if (MUL_LAT == 1) begin : g_mul_nopipe
    assign mul_tap = mul_word;
  end else begin : g_mul_pipe
    logic [XLEN-1:0] pipe_q [MUL_LAT-1];
    always_ff @(posedge clk) begin
      pipe_q[0] <= mul_word;
      for (int i = 1; i < int'(MUL_LAT) - 1; i++) pipe_q[i] <= pipe_q[i-1];
    end
    assign mul_tap = pipe_q[MUL_LAT-2];
  end

  logic            div_start, div_done;
  logic [XLEN-1:0] div_quot, div_rem, quot_fix, rem_fix;

  muldiv_divider #(.XLEN(XLEN)) u_div (
    .clk        (clk),
    .rst_i      (Rst),
    .start_i    (div_start),
    .flush_i    (mdu.flush),
    .dividend_i (a_mag),
    .divisor_i  (b_mag),
    .quot_o     (div_quot),
    .rem_o      (div_rem),
    .done_c_o   (div_done)
  );

  assign quot_fix = qneg_q ? -div_quot : div_quot;
  assign rem_fix  = rneg_q ? -div_rem  : div_rem;

  // RISC-V defined results for divide-by-zero and signed overflow.
  function automatic logic [XLEN-1:0] special_result(logic rem_sel, logic dz,
                                                     logic [XLEN-1:0] a);
    if (dz) return rem_sel ? a : '1;
    return rem_sel ? '0 : a;
  endfunction

  // Next-state / datapath control.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    res_d     = res_q;
    rd_d      = rd_q;
    a_d       = a_q;
    rem_sel_d = rem_sel_q;
    dz_d      = dz_q;
    spec_d    = spec_q;
    qneg_d    = qneg_q;
    rneg_d    = rneg_q;
    div_start = 1'b0;
    if (mdu.flush) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (mdu.start) begin
            rd_d      = mdu.rd_in;
            a_d       = mdu.a;
            rem_sel_d = op_in[1];
            dz_d      = dz_in;
            spec_d    = spec_in;
            qneg_d    = a_sgn && (mdu.a[XLEN-1] ^ mdu.b[XLEN-1]);
            rneg_d    = a_sgn && mdu.a[XLEN-1];
            cnt_d     = '0;
            if (!is_div_op(op_in)) begin
              if (MUL_LAT == 1) begin
                res_d   = mul_tap;
                state_d = ST_DONE;
              end else begin
                state_d = ST_MUL;
              end
            end else if ((EARLY_OUT != 0) && spec_in) begin
              res_d   = special_result(op_in[1], dz_in, mdu.a);
              state_d = ST_DONE;
            end else begin
              div_start = 1'b1;
              state_d   = ST_DIV;
            end
          end
        end
        ST_MUL: begin
          if (cnt_q == CNT_W'(MUL_LAT - 2)) begin
            res_d   = mul_tap;
            state_d = ST_DONE;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        ST_DIV: begin
          if (div_done) state_d = ST_FIX;
        end
        ST_FIX: begin
          res_d   = spec_q ? special_result(rem_sel_q, dz_q, a_q)
                           : (rem_sel_q ? rem_fix : quot_fix);
          state_d = ST_DONE;
        end
        ST_DONE: begin
          if (!mdu.hold) state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (Rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      res_q     <= '0;
      rd_q      <= '0;
      a_q       <= '0;
      rem_sel_q <= 1'b0;
      dz_q      <= 1'b0;
      spec_q    <= 1'b0;
      qneg_q    <= 1'b0;
      rneg_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      res_q     <= res_d;
      rd_q      <= rd_d;
      a_q       <= a_d;
      rem_sel_q <= rem_sel_d;
      dz_q      <= dz_d;
      spec_q    <= spec_d;
      qneg_q    <= qneg_d;
      rneg_q    <= rneg_d;
    end
  end

  // Stall drops in an unheld DONE cycle so EX/MEM captures the result.
  assign mdu.stall     = ((state_q == ST_IDLE) && mdu.start) ||
                         ((state_q != ST_IDLE) && (state_q != ST_DONE)) ||
                         ((state_q == ST_DONE) && mdu.hold);
  assign mdu.res_valid = (state_q == ST_DONE) && !mdu.flush;
  assign mdu.res       = res_q;
  assign mdu.rd_out    = rd_q;

  // A request while busy means the pipeline ignored stall.
  start_while_busy_a: assert property (@(posedge clk) disable iff (Rst)
    !(mdu.start && !mdu.flush && (state_q != ST_IDLE)));

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Self-checking bench for ex_muldiv_unit (XLEN=32, MUL_LAT=3, EARLY_OUT=1).
module tb_ex_muldiv_unit;
  import muldiv_pkg::*;

  localparam int unsigned XLEN      = 32;
  localparam int unsigned MUL_LAT   = 3;
  localparam int unsigned EARLY_OUT = 1;
  localparam int unsigned DIV_LAT   = XLEN + 2;

  logic clk = 1'b0;
  logic Rst;
  always #5 clk = ~clk;

  ex_muldiv_unit_if #(.XLEN(XLEN)) bus ();

  ex_muldiv_unit #(.XLEN(XLEN), .MUL_LAT(MUL_LAT), .EARLY_OUT(EARLY_OUT)) u_dut (
    .clk (clk),
    .Rst (Rst),
    .mdu (bus)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: RISC-V M semantics in plain 64-bit arithmetic.
  function automatic logic [31:0] ref_result(logic [2:0] op, logic [31:0] a, logic [31:0] b);
    longint          sa = $signed(a);
    longint          sb = $signed(b);
    longint unsigned ua = 64'(a);
    longint unsigned ub = 64'(b);
    longint          p;
    longint unsigned pu;
    logic            ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (op)
      3'd0: begin p = sa * sb; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * longint'(ub); return p[63:32]; end
      3'd3: begin pu = ua * ub; return pu[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (ovf) return a;
        return $signed(a) / $signed(b);
      end
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (ovf) return 32'h0;
        return $signed(a) % $signed(b);
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int exp_lat(logic [2:0] op, logic [31:0] a, logic [31:0] b);
    if (!op[2]) return int'(MUL_LAT);
    if (EARLY_OUT != 0 && (b == 0 || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)))
      return 1;
    return int'(DIV_LAT);
  endfunction

  task automatic junk_inputs();
    bus.start = 1'b0;
    bus.op    = 3'($urandom);
    bus.a     = $urandom;
    bus.b     = $urandom;
    bus.rd_in = 5'($urandom);
  endtask

  // Issue one request in the current cycle (k) and follow it to IDLE.
  task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] rd,
                        input logic [31:0] exp, input bit wait_edge);
    int lat = exp_lat(op, a, b);
    bit ok  = 1'b1;
    if (wait_edge) @(negedge clk);
    bus.start = 1'b1; bus.op = op; bus.a = a; bus.b = b; bus.rd_in = rd;
    #1;
    if (bus.stall !== 1'b1 || bus.res_valid !== 1'b0) ok = 1'b0;
    for (int c = 1; c < lat; c++) begin
      @(negedge clk); junk_inputs(); #1;
      if (bus.stall !== 1'b1 || bus.res_valid !== 1'b0) ok = 1'b0;
    end
    @(negedge clk); junk_inputs(); #1;
    chk({tag, "/busy_window"}, 64'(ok), 64'd1);
    chk({tag, "/valid"}, 64'(bus.res_valid), 64'd1);
    chk({tag, "/res"}, 64'(bus.res), 64'(exp));
    chk({tag, "/rd"}, 64'(bus.rd_out), 64'(rd));
    chk({tag, "/stall_done"}, 64'(bus.stall), 64'd0);
    @(negedge clk); junk_inputs(); #1;
    chk({tag, "/idle_after"}, 64'({bus.res_valid, bus.stall}), 64'd0);
  endtask

  initial begin
    Rst = 1'b1;
    bus.start = 1'b0; bus.op = '0; bus.a = '0; bus.b = '0; bus.rd_in = '0;
    bus.flush = 1'b0; bus.hold = 1'b0;
    repeat (3) @(negedge clk);
    Rst = 1'b0;
    #1;
    chk("reset/stall", 64'(bus.stall), 64'd0);
    chk("reset/valid", 64'(bus.res_valid), 64'd0);
    chk("reset/res", 64'(bus.res), 64'd0);
    chk("reset/rd", 64'(bus.rd_out), 64'd0);

    // Directed multiply and divide cases
    run_op("mul",    3'd0, 32'd7,          32'hFFFF_FFFD, 5'd3,  32'hFFFF_FFEB, 1'b1);
    run_op("mulh",   3'd1, 32'h8000_0000,  32'h8000_0000, 5'd4,  32'h4000_0000, 1'b1);
    run_op("mulhu",  3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 5'd5,  32'hFFFF_FFFE, 1'b1);
    run_op("mulhsu", 3'd2, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 5'd6,  32'hFFFF_FFFF, 1'b1);
    run_op("div",    3'd4, 32'hFFFF_FFF9,  32'd2,         5'd7,  32'hFFFF_FFFD, 1'b1);
    run_op("rem",    3'd6, 32'hFFFF_FFF9,  32'd2,         5'd8,  32'hFFFF_FFFF, 1'b1);
    run_op("divu",   3'd5, 32'd100,        32'd7,         5'd9,  32'd14,        1'b1);
    run_op("remu",   3'd7, 32'd100,        32'd7,         5'd0,  32'd2,         1'b1);
    run_op("divu0",  3'd5, 32'd5,          32'd0,         5'd10, 32'hFFFF_FFFF, 1'b1);
    run_op("remu0",  3'd7, 32'd5,          32'd0,         5'd11, 32'd5,         1'b1);
    run_op("div0",   3'd4, 32'hFFFF_FFF9,  32'd0,         5'd12, 32'hFFFF_FFFF, 1'b1);
    run_op("rem0",   3'd6, 32'hFFFF_FFF9,  32'd0,         5'd13, 32'hFFFF_FFF9, 1'b1);
    run_op("divovf", 3'd4, 32'h8000_0000,  32'hFFFF_FFFF, 5'd14, 32'h8000_0000, 1'b1);
    run_op("removf", 3'd6, 32'h8000_0000,  32'hFFFF_FFFF, 5'd15, 32'd0,         1'b1);

    // Hold in DONE for 4 cycles, then release
    @(negedge clk);
    bus.start = 1'b1; bus.op = 3'd0; bus.a = 32'h0001_2345; bus.b = 32'h10; bus.rd_in = 5'd9;
    #1;
    @(negedge clk); junk_inputs(); bus.hold = 1'b1; #1;
    @(negedge clk); junk_inputs(); #1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk); junk_inputs(); #1;
      chk("hold/valid", 64'(bus.res_valid), 64'd1);
      chk("hold/stall", 64'(bus.stall), 64'd1);
      chk("hold/res", 64'(bus.res), 64'h0012_3450);
      chk("hold/rd", 64'(bus.rd_out), 64'd9);
    end
    @(negedge clk); bus.hold = 1'b0; #1;
    chk("release/valid", 64'(bus.res_valid), 64'd1);
    chk("release/stall", 64'(bus.stall), 64'd0);
    @(negedge clk); #1;
    chk("release/idle", 64'({bus.res_valid, bus.stall}), 64'd0);

    // Flush at k+10 of a divide, back-to-back start at k+11
    @(negedge clk);
    bus.start = 1'b1; bus.op = 3'd5; bus.a = 32'd1000; bus.b = 32'd3; bus.rd_in = 5'd17;
    #1;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk); junk_inputs(); bus.flush = (c == 10); #1;
    end
    @(negedge clk); bus.flush = 1'b0; junk_inputs(); #1;
    chk("flush/idle", 64'({bus.res_valid, bus.stall}), 64'd0);
    run_op("after_flush", 3'd4, 32'hFFFF_FF9C, 32'd7, 5'd18, 32'hFFFF_FFF2, 1'b0);

    // Flush and start together: request is dropped
    begin
      bit quiet = 1'b1;
      @(negedge clk);
      bus.start = 1'b1; bus.flush = 1'b1; bus.op = 3'd0; bus.a = 32'd3; bus.b = 32'd3;
      bus.rd_in = 5'd20;
      @(negedge clk); bus.flush = 1'b0; junk_inputs(); #1;
      chk("flush_start/idle", 64'({bus.res_valid, bus.stall}), 64'd0);
      for (int c = 0; c < 40; c++) begin
        @(negedge clk); #1;
        if (bus.res_valid !== 1'b0) quiet = 1'b0;
      end
      chk("flush_start/no_result", 64'(quiet), 64'd1);
    end

    // Reset in the middle of a multiply
    @(negedge clk);
    bus.start = 1'b1; bus.op = 3'd0; bus.a = 32'd3; bus.b = 32'd5; bus.rd_in = 5'd11;
    #1;
    @(negedge clk); junk_inputs(); Rst = 1'b1;
    @(negedge clk); Rst = 1'b0; #1;
    chk("rst_mid/outs", 64'({bus.stall, bus.res_valid, bus.rd_out}), 64'd0);
    chk("rst_mid/res", 64'(bus.res), 64'd0);
    @(negedge clk); #1;
    chk("rst_mid/no_result", 64'(bus.res_valid), 64'd0);

    // Randomized operations against the reference model
    for (int i = 0; i < 40; i++) begin
      logic [2:0]  op;
      logic [31:0] a, b;
      int          mode;
      op   = 3'($urandom_range(0, 7));
      a    = $urandom;
      b    = $urandom;
      mode = $urandom_range(0, 9);
      if (mode == 0) b = 32'd0;
      else if (mode == 1) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
      else if (mode == 2) b = 32'd1;
      else if (mode == 3) b = 32'($urandom_range(1, 15));
      run_op($sformatf("rnd%0d_op%0d", i, op), op, a, b, 5'($urandom), ref_result(op, a, b), 1'b1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
